// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int          XLEN_C      = 32;
  localparam logic [31:0] NOP_INSTR_C = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic              valid;
    logic              fault;
    logic [31:0]       instr;
    logic [XLEN_C-1:0] pc;
    logic [XLEN_C-1:0] pc_plus4;
  } if_id_entry_t;

  // Build a valid IF/ID entry; pc_plus4 wraps naturally modulo 2^XLEN.
  function automatic if_id_entry_t make_entry(input logic              fault,
                                              input logic [31:0]       instr,
                                              input logic [XLEN_C-1:0] pc);
    if_id_entry_t e;
    e.valid    = 1'b1;
    e.fault    = fault;
    e.instr    = instr;
    e.pc       = pc;
    e.pc_plus4 = pc + {{(XLEN_C-3){1'b0}}, 3'd4};
    return e;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an IF/ID entry that arrives while decode
// is stalled. Flush empties it; push has priority over pop (they never
// coincide in the fetch unit).
module fetch_skid_buf
  import if_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  if_id_entry_t din,
  output logic         full,
  output if_id_entry_t dout
);

  logic         full_q;
  if_id_entry_t data_q;

  // Occupancy and stored entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (flush) begin
      full_q <= 1'b0;
      data_q <= data_q;
    end else if (push) begin
      full_q <= 1'b1;
      data_q <= din;
    end else if (pop) begin
      full_q <= 1'b0;
      data_q <= data_q;
    end else begin
      full_q <= full_q;
      data_q <= data_q;
    end
  end

  assign full = full_q;
  assign dout = data_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues one request at a time to instruction
// memory, tracks the outstanding fetch, and fills the IF/ID register with
// a one-entry skid buffer behind it.
// Optional build macro: FETCH_MISALIGN_EN (misaligned PC produces a fault
// entry instead of a memory request).
module if_fetch_unit
  import if_fetch_pkg::*;
#(
  parameter int          XLEN      = XLEN_C,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic            redirect,
  input  logic            stall_d,
  output logic            pc_en,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_id_valid,
  output logic [31:0]     if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic            if_id_fault
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_REQ  = REQ;
  localparam logic [1:0] ST_WAIT = WAIT;

  logic [1:0]      state, state_nxt;
  logic            drop, drop_nxt;
  logic [XLEN-1:0] pend_pc;
  if_id_entry_t    if_id_q, if_id_nxt, new_entry, skid_dout;
  logic            skid_full, skid_push, skid_pop;
  logic            misalign, fire, rsp_take, fault_take, new_valid, if_id_load;

`ifdef FETCH_MISALIGN_EN
  assign misalign = (pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Request side: no request while the skid holds an entry, so a response
  // can never collide with a skid drain.
  assign imem_req_valid = !reset && (state == ST_REQ) && !skid_full && !misalign;
  assign imem_req_addr  = pc;
  assign fire           = imem_req_valid && imem_req_ready && !redirect;
  assign pc_en          = !reset && (redirect || fire);

  // A response is used only if no flush killed it while in flight.
  assign rsp_take   = (state == ST_WAIT) && imem_rsp_valid && !drop && !redirect;
  assign fault_take = (state == ST_REQ) && misalign && !skid_full && !redirect;
  assign new_valid  = rsp_take || fault_take;
  assign if_id_load = !if_id_q.valid || !stall_d;
  assign skid_push  = !redirect && !if_id_load && new_valid;
  assign skid_pop   = !redirect && if_id_load && skid_full;

  // Select the candidate entry: memory data or a misaligned-fetch fault.
  always_comb begin
    if (rsp_take) begin
      new_entry = make_entry(1'b0, imem_rsp_data, pend_pc);
    end else begin
      new_entry = make_entry(1'b1, NOP_INSTR, pc);
    end
  end

  // Next-state and drop-flag logic; a redirect while waiting poisons the
  // in-flight response unless it returns in the same cycle.
  always_comb begin
    state_nxt = state;
    drop_nxt  = drop;
    case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ: begin
        if (fire) begin
          state_nxt = ST_WAIT;
        end else begin
          state_nxt = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          state_nxt = ST_REQ;
          drop_nxt  = 1'b0;
        end else if (redirect) begin
          drop_nxt  = 1'b1;
        end else begin
          drop_nxt  = drop;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        drop_nxt  = 1'b0;
      end
    endcase
  end

  // IF/ID next value: redirect flushes, stall holds, skid drains before new data.
  always_comb begin
    if_id_nxt = if_id_q;
    if (redirect) begin
      if_id_nxt.valid = 1'b0;
      if_id_nxt.fault = 1'b0;
      if_id_nxt.instr = NOP_INSTR;
    end else if (if_id_load) begin
      if (skid_full) begin
        if_id_nxt = skid_dout;
      end else if (new_valid) begin
        if_id_nxt = new_entry;
      end else begin
        if_id_nxt.valid = 1'b0;
        if_id_nxt.fault = 1'b0;
      end
    end else begin
      if_id_nxt = if_id_q;
    end
  end

  // FSM, drop flag and pending-PC registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      drop    <= 1'b0;
      pend_pc <= '0;
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
      if (fire) begin
        pend_pc <= pc;
      end else begin
        pend_pc <= pend_pc;
      end
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_q          <= '0;
      if_id_q.instr    <= NOP_INSTR;
    end else begin
      if_id_q <= if_id_nxt;
    end
  end

  fetch_skid_buf u_skid (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (skid_push),
    .pop   (skid_pop),
    .din   (new_entry),
    .full  (skid_full),
    .dout  (skid_dout)
  );

  assign if_id_valid    = if_id_q.valid;
  assign if_id_instr    = if_id_q.instr;
  assign if_id_pc       = if_id_q.pc;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
  assign if_id_fault    = if_id_q.fault;

endmodule
